// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: one ALU and one MULT pick per cycle with
// XOR-rotated priority, plus single-CDB writeback slot reservation tracking.
module rs_issue_sched #(
  parameter int unsigned RS_SIZE  = 8,
  parameter int unsigned MULT_LAT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       squash,
  input  logic [RS_SIZE-1:0]         ready,
  input  logic [RS_SIZE-1:0]         is_mult,
  output logic [RS_SIZE-1:0]         alu_gnt,
  output logic [RS_SIZE-1:0]         mult_gnt,
  output logic                       alu_issue,
  output logic                       mult_issue,
  output logic [1:0]                 wb_src,
  output logic [$clog2(RS_SIZE)-1:0] alu_ptr,
  output logic [$clog2(RS_SIZE)-1:0] mult_ptr
);

  localparam int unsigned PW = $clog2(RS_SIZE);

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MULT = 2'd2
  } wb_owner_e;

  // res_q[k] holds the owner of CDB slot (now + k + 1).
  wb_owner_e         res_q [MULT_LAT];
  wb_owner_e         res_d [MULT_LAT];
  wb_owner_e         wb_src_q, wb_src_d;
  logic [PW-1:0]     alu_ptr_q, alu_ptr_d;
  logic [PW-1:0]     mult_ptr_q, mult_ptr_d;
  logic [RS_SIZE-1:0] alu_req, mult_req;
  logic              issue_ok, alu_blocked, mult_blocked;

  // Winner is the requester with the smallest (index XOR p).
  function automatic logic [RS_SIZE-1:0] pick(input logic [RS_SIZE-1:0] req,
                                              input logic [PW-1:0]      p);
    logic [RS_SIZE-1:0] g;
    logic [PW-1:0]      idx;
    g = '0;
    for (int unsigned j = RS_SIZE; j > 0; j--) begin
      idx = PW'(j - 1) ^ p;
      if (req[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    alu_req      = ready & ~is_mult;
    mult_req     = ready & is_mult;
    issue_ok     = en & ~squash & ~reset;
    alu_blocked  = (res_q[0] != WB_NONE);
    mult_blocked = (res_q[MULT_LAT-1] != WB_NONE);

    alu_gnt    = (issue_ok && !alu_blocked)  ? pick(alu_req,  alu_ptr_q)  : '0;
    mult_gnt   = (issue_ok && !mult_blocked) ? pick(mult_req, mult_ptr_q) : '0;
    alu_issue  = |alu_gnt;
    mult_issue = |mult_gnt;

    alu_ptr_d  = alu_issue  ? alu_ptr_q + 1'b1  : alu_ptr_q;
    mult_ptr_d = mult_issue ? mult_ptr_q + 1'b1 : mult_ptr_q;

    // After the shift, slot (now + MULT_LAT) sits at index MULT_LAT-2.
    for (int unsigned k = 0; k < MULT_LAT - 1; k++) begin
      res_d[k] = res_q[k+1];
    end
    res_d[MULT_LAT-1] = WB_NONE;
    if (mult_issue) res_d[MULT_LAT-2] = WB_MULT;

    wb_src_d = alu_issue ? WB_ALU : res_q[0];

    if (squash) begin
      for (int unsigned k = 0; k < MULT_LAT; k++) begin
        res_d[k] = WB_NONE;
      end
      wb_src_d = WB_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_ptr_q  <= '0;
      mult_ptr_q <= '0;
      wb_src_q   <= WB_NONE;
      res_q      <= '{default: WB_NONE};
    end else begin
      alu_ptr_q  <= alu_ptr_d;
      mult_ptr_q <= mult_ptr_d;
      wb_src_q   <= wb_src_d;
      res_q      <= res_d;
    end
  end

  assign wb_src   = wb_src_q;
  assign alu_ptr  = alu_ptr_q;
  assign mult_ptr = mult_ptr_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Scoreboarded bench for rs_issue_sched: a slot-calendar reference model predicts
// each cycle's grants, pointers and CDB owner; a negedge monitor compares.
module tb_rs_issue_sched;

  localparam int N  = 8;
  localparam int ML = 4;
  localparam int MAXC = 4096;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         squash = 1'b0;
  logic [N-1:0] ready = '0;
  logic [N-1:0] is_mult = '0;
  logic [N-1:0] alu_gnt, mult_gnt;
  logic         alu_issue, mult_issue;
  logic [1:0]   wb_src;
  logic [2:0]   alu_ptr, mult_ptr;

  rs_issue_sched #(.RS_SIZE(N), .MULT_LAT(ML)) dut (
    .clock(clock), .reset(reset), .en(en), .squash(squash),
    .ready(ready), .is_mult(is_mult),
    .alu_gnt(alu_gnt), .mult_gnt(mult_gnt),
    .alu_issue(alu_issue), .mult_issue(mult_issue),
    .wb_src(wb_src), .alu_ptr(alu_ptr), .mult_ptr(mult_ptr)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [7:0] ag;
    logic [7:0] mg;
    int         ap;
    int         mp;
    int         wb;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: absolute-cycle calendar of CDB owners (0 none, 1 ALU, 2 MULT).
  int   owner [MAXC];
  int   cyc = 0;
  int   aptr = 0;
  int   mptr = 0;

  function automatic logic [7:0] ref_pick(logic [7:0] req, int p);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (req[i] && (best < 0 || (i ^ p) < (best ^ p))) best = i;
    if (best < 0) return 8'h00;
    return 8'(1 << best);
  endfunction

  task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  task automatic step(input logic i_en, input logic i_sq, input logic i_rst,
                      input logic [7:0] i_rdy, input logic [7:0] i_mul);
    exp_t e;
    logic [7:0] areq, mreq;
    logic ok;
    @(posedge clock);
    #1;
    en = i_en; squash = i_sq; reset = i_rst; ready = i_rdy; is_mult = i_mul;
    areq = i_rdy & ~i_mul;
    mreq = i_rdy & i_mul;
    ok = i_en && !i_sq && !i_rst;
    e.cyc = cyc;
    e.ap  = aptr;
    e.mp  = mptr;
    e.wb  = owner[cyc];
    e.ag  = (ok && owner[cyc+1] == 0)  ? ref_pick(areq, aptr) : 8'h00;
    e.mg  = (ok && owner[cyc+ML] == 0) ? ref_pick(mreq, mptr) : 8'h00;
    sb.push_back(e);
    if (i_rst || i_sq) begin
      for (int k = cyc + 1; k <= cyc + ML; k++) owner[k] = 0;
      if (i_rst) begin aptr = 0; mptr = 0; end
    end else begin
      if (e.ag != 0) begin owner[cyc+1]  = 1; aptr = (aptr + 1) % N; end
      if (e.mg != 0) begin owner[cyc+ML] = 2; mptr = (mptr + 1) % N; end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alu_gnt",    e.cyc, 32'(alu_gnt),    32'(e.ag));
        chk("mult_gnt",   e.cyc, 32'(mult_gnt),   32'(e.mg));
        chk("alu_issue",  e.cyc, 32'(alu_issue),  32'(e.ag != 0));
        chk("mult_issue", e.cyc, 32'(mult_issue), 32'(e.mg != 0));
        chk("wb_src",     e.cyc, 32'(wb_src),     32'(e.wb));
        chk("alu_ptr",    e.cyc, 32'(alu_ptr),    32'(e.ap));
        chk("mult_ptr",   e.cyc, 32'(mult_ptr),   32'(e.mp));
      end
    end
  end

  initial begin : driver
    int guard;
    for (int k = 0; k < MAXC; k++) owner[k] = 0;

    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

    // back-to-back ALU grants
    step(1'b1, 1'b0, 1'b0, 8'h0F, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h0F, 8'h00);
    idle(2);

    // MULT slot blocks a later ALU grant for one cycle
    step(1'b1, 1'b0, 1'b0, 8'h08, 8'h08);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    idle(3);

    // simultaneous ALU and MULT
    step(1'b1, 1'b0, 1'b0, 8'h03, 8'h02);
    idle(5);

    // squash drops an in-flight MULT and frees its slot
    step(1'b1, 1'b0, 1'b0, 8'h08, 8'h08);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h0F);
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    idle(4);

    // rotate ALU pointer to 5, then wrap with all entries ready
    guard = 0;
    while (aptr != 5 && guard < 20) begin
      step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
      guard++;
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    idle(2);

    // reset during a pending MULT
    step(1'b1, 1'b0, 1'b0, 8'h40, 8'h40);
    step(1'b1, 1'b0, 1'b1, 8'hFF, 8'h0F);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 8) != 0, ($urandom % 32) == 0, ($urandom % 128) == 0,
           8'($urandom), 8'($urandom));
    end
    idle(ML + 1);

    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Issue scheduler for the reservation station. Each cycle it picks at most one ready ALU entry and at most one ready multiplier entry using XOR-rotated tree priority, with a separate walking pointer per class. It tracks single-CDB writeback slot reservations so that ALU (1-cycle) and pipelined multiplier (MULT_LAT-cycle) results never collide on the CDB. It sits between the RS ready/type vectors and the FU issue registers, and its registered `wb_src` steers the CDB mux.

## Interface
- N, `RS_SIZE`, number of RS entries; power of 2, ≥2
- MULT_LAT, 4, multiplier issue-to-writeback latency in cycles; ≥2
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  issue enable; 0 = no grants this cycle
- squash  in  1  synchronous flush of in-flight reservations
- ready  in  N  entry i has all operands ready
- is_mult  in  N  entry i targets the multiplier (0 = ALU)
- alu_gnt  out  N  one-hot (or zero) ALU grant, combinational
- mult_gnt  out  N  one-hot (or zero) MULT grant, combinational
- alu_issue  out  1  |alu_gnt
- mult_issue  out  1  |mult_gnt
- wb_src  out  2  registered CDB owner this cycle: 0 NONE, 1 ALU, 2 MULT
- alu_ptr, mult_ptr  out  $clog2(N) each  current rotation pointers (debug/verif)

## Operation
- Requests: alu_req = ready & ~is_mult; mult_req = ready & is_mult.
- Priority within a class with pointer p: the winner is the requesting index i with the smallest (i XOR p). p = 0 gives lowest-index-first; p = N-1 gives highest-index-first.
- ALU issue at cycle t owns CDB slot t+1. MULT issue at t owns slot t+MULT_LAT.
- A class is blocked when its target slot is already reserved. A blocked class outputs a zero grant and its pointer holds.
- ALU and MULT may issue in the same cycle. Their slots always differ because MULT_LAT ≥ 2.
- Reservation state:
  - MULT_LAT-deep shift register of {valid, owner}, advancing every cycle regardless of en.
  - wb_src is registered from the entry reaching slot 0.
- Pointer update:
  - On a class grant (en=1, not blocked, not squash), that pointer increments by 1, mod N (wraps N-1 → 0).
  - Otherwise the pointer holds.
- en=0: both grants zero and pointers hold. Reservations keep draining, so in-flight results still appear on wb_src.
- squash=1:
  - Grants forced to zero that cycle; pointers hold.
  - All reservations cleared at the edge, so wb_src = NONE from the next cycle until new issues land.
- reset=1: alu_ptr = mult_ptr = 0, all reservations invalid, wb_src = 0. Grants are zero while reset is high.
- Invariants:
  - alu_gnt & mult_gnt == 0.
  - Each grant is a subset of its class request.
  - At most one bit set per grant vector.

## Timing
- Grants are combinational from ready, is_mult, en, squash, pointers and reservation state. There are no combinational paths into pointer or reservation registers other than through the grants.
- wb_src latency: ALU grant at t → wb_src = 1 during t+1. MULT grant at t → wb_src = 2 during t+MULT_LAT.
- A MULT grant at t blocks an ALU grant at t+MULT_LAT-1. The ALU may issue at t+MULT_LAT.
- Back-to-back ALU grants every cycle are legal when no MULT slot conflicts; the same holds for MULT.
- Reset or squash asserted mid-operation takes priority over all issue; in-flight results are dropped.

## Test plan
- N=8, reset, then ready=0x0F, is_mult=0, en=1 for 2 cycles:
  - Cycle 0: alu_gnt=0x01, alu_ptr 0→1.
  - Cycle 1: alu_gnt=0x02.
  - wb_src=1 in cycles 1 and 2.
- MULT_LAT=4, cycle 0: ready=0x08, is_mult=0x08 → mult_gnt=0x08.
  - Cycle 3: ALU request ready=0x01 → alu_gnt=0; it grants in cycle 4.
  - wb_src=2 in cycle 4 and 1 in cycle 5.
- Cycle 0: ready=0x03, is_mult=0x02 → alu_gnt=0x01 and mult_gnt=0x02 together; wb_src=1 in cycle 1 and 2 in cycle 4.
- MULT grant in cycle 0, squash in cycle 2:
  - wb_src=0 in cycle 4.
  - An ALU grant in cycle 3 is not blocked (alu_gnt=0x01 with ready=0x01).
- Pointer rotation and wrap:
  - Drive ALU grants until alu_ptr=5, then ready=0xFF, is_mult=0 → alu_gnt=0x20, then 0x40, 0x80, and after wrap 0x01 when ptr=0.
  - With en=0, alu_ptr holds.
- Assert reset during a pending MULT (granted cycle 0, reset cycle 1) → wb_src=0 through cycle 5; both pointers read 0.
